seg_scan_driver: RTL

Parametrised, time-multiplexed seven-segment display driver for the parking system's multi-digit counters (free spaces, status codes). It takes a packed BCD word for DIGITS digits and scans one common-anode/cathode digit at a time. It adds tear-free frame-boundary updates, leading-zero suppression, per-digit blink and decimal point, and anti-ghosting guard time. Output polarity is selectable. It replaces per-digit combinational decoders, and sits between the occupancy/control logic and the board display pins.

---
 rtl/seg_scan_driver.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner: shadowed BCD digits, frame-boundary
// commit, leading-zero blanking, per-digit blink/dp and anode guard time.

module seg_scan_digit #(
  parameter bit LZ_OK = 1'b1
) (
  input  logic [3:0] code_i,
  input  logic       blink_i,
  input  logic       bphase_i,
  input  logic       lz_en_i,
  input  logic       zero_above_i,
  output logic       zero_here_o,
  output logic       dark_o,
  output logic       blank_o
);
  // zero_here_o: this digit and every more-significant digit hold code 0
  assign zero_here_o = zero_above_i & (code_i == 4'd0);
  assign dark_o      = bphase_i & blink_i;
  assign blank_o     = LZ_OK & lz_en_i & zero_here_o;
endmodule

module seg_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink_en,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PC_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PC_GUARD = PW'(GUARD);
  localparam logic [FW-1:0] FC_LAST  = FW'(BLINK_FRAMES - 1);
  localparam logic          INV      = (ACTIVE_LOW != 0);

  logic [PW-1:0] pc_q, pc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] fc_q, fc_d;
  logic          bphase_q, bphase_d;

  logic [DIGITS-1:0][3:0] pend_code_q, pend_code_d, sh_code_q, sh_code_d;
  logic [DIGITS-1:0]      pend_dp_q, pend_dp_d, sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]      pend_bl_q, pend_bl_d, sh_bl_q, sh_bl_d;
  logic                   pend_valid_q, pend_valid_d;

  logic [6:0]        seg_q, seg_d;
  logic              seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              tick_q, tick_d;

  logic              pc_last, wrap;
  logic [DIGITS:0]   zchain;
  logic [DIGITS-1:0] dark, blank;
  logic              unused_all_zero;
  logic [6:0]        lit;
  logic [DIGITS-1:0] an_lit;
  logic              dp_lit;

  function automatic logic [6:0] dec7(input logic [3:0] c);
    case (c)
      4'd0:    dec7 = 7'b1111110;
      4'd1:    dec7 = 7'b0110000;
      4'd2:    dec7 = 7'b1101101;
      4'd3:    dec7 = 7'b1111001;
      4'd4:    dec7 = 7'b0110011;
      4'd5:    dec7 = 7'b1011011;
      4'd6:    dec7 = 7'b1011111;
      4'd7:    dec7 = 7'b1110000;
      4'd8:    dec7 = 7'b1111111;
      4'd9:    dec7 = 7'b1111011;
      4'd10:   dec7 = 7'b1000111;
      4'd11:   dec7 = 7'b0000001;
      default: dec7 = 7'b0000000;
    endcase
  endfunction

  // Leading-zero chain runs from the most significant digit downwards
  assign zchain[DIGITS]  = 1'b1;
  assign unused_all_zero = zchain[0];

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    seg_scan_digit #(.LZ_OK(k != 0)) u_dig (
      .code_i       (sh_code_q[k]),
      .blink_i      (sh_bl_q[k]),
      .bphase_i     (bphase_q),
      .lz_en_i      (lz_en),
      .zero_above_i (zchain[k+1]),
      .zero_here_o  (zchain[k]),
      .dark_o       (dark[k]),
      .blank_o      (blank[k])
    );
  end

  assign pc_last = (pc_q == PC_LAST);
  assign wrap    = pc_last && (idx_q == IDX_LAST);

  always_comb begin
    pc_d     = pc_last ? '0 : pc_q + 1'b1;
    idx_d    = idx_q;
    fc_d     = fc_q;
    bphase_d = bphase_q;
    if (pc_last) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    if (wrap) begin
      if (fc_q == FC_LAST) begin
        fc_d     = '0;
        bphase_d = ~bphase_q;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end

    pend_code_d  = pend_code_q;
    pend_dp_d    = pend_dp_q;
    pend_bl_d    = pend_bl_q;
    pend_valid_d = pend_valid_q;
    sh_code_d    = sh_code_q;
    sh_dp_d      = sh_dp_q;
    sh_bl_d      = sh_bl_q;
    if (wrap && pend_valid_q) begin
      sh_code_d    = pend_code_q;
      sh_dp_d      = pend_dp_q;
      sh_bl_d      = pend_bl_q;
      pend_valid_d = 1'b0;
    end
    // A load on the wrap edge lands in pending only; it commits next frame
    if (load) begin
      pend_code_d  = value;
      pend_dp_d    = dp;
      pend_bl_d    = blink_en;
      pend_valid_d = 1'b1;
    end

    lit    = (dark[idx_q] || blank[idx_q]) ? 7'b0000000 : dec7(sh_code_q[idx_q]);
    dp_lit = sh_dp_q[idx_q] & ~dark[idx_q];
    an_lit = '0;
    if (pc_q >= PC_GUARD && !dark[idx_q]) an_lit[idx_q] = 1'b1;

    seg_d    = lit ^ {7{INV}};
    seg_dp_d = dp_lit ^ INV;
    an_d     = an_lit ^ {DIGITS{INV}};
    tick_d   = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= '0;
      idx_q        <= '0;
      fc_q         <= '0;
      bphase_q     <= 1'b0;
      pend_code_q  <= '0;
      pend_dp_q    <= '0;
      pend_bl_q    <= '0;
      pend_valid_q <= 1'b0;
      sh_code_q    <= '0;
      sh_dp_q      <= '0;
      sh_bl_q      <= '0;
      seg_q        <= {7{INV}};
      seg_dp_q     <= INV;
      an_q         <= {DIGITS{INV}};
      tick_q       <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      idx_q        <= idx_d;
      fc_q         <= fc_d;
      bphase_q     <= bphase_d;
      pend_code_q  <= pend_code_d;
      pend_dp_q    <= pend_dp_d;
      pend_bl_q    <= pend_bl_d;
      pend_valid_q <= pend_valid_d;
      sh_code_q    <= sh_code_d;
      sh_dp_q      <= sh_dp_d;
      sh_bl_q      <= sh_bl_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      an_q         <= an_d;
      tick_q       <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;
endmodule
